// File: rtl/dqn_sequencer.sv
// Phase/step/episode sequencer for the DQN training datapath.
// The datapath decodes phase; step_end/episode_end/term_goal are registered one-cycle event pulses.
module dqn_sequencer #(
  parameter int PHASES      = 9,
  parameter int MAX_STEP    = 15,
  parameter int MAX_EPISODE = 4095,
  parameter int PH_W        = 4,
  parameter int STEP_W      = 4,
  parameter int EP_W        = 12,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  input  logic [STATE_W-1:0] st1,
  input  logic [STATE_W-1:0] goal_state,
  output logic [PH_W-1:0]    phase,
  output logic [STEP_W-1:0]  step,
  output logic [EP_W-1:0]    episode,
  output logic               step_end,
  output logic               episode_end,
  output logic               term_goal,
  output logic               busy,
  output logic               done
);

  if (PHASES < 2 || PHASES >= (1 << PH_W)) begin : g_bad_phases
    $error("dqn_sequencer: PHASES must be >= 2 and fit in PH_W bits");
  end
  if (MAX_STEP < 1 || MAX_STEP >= (1 << STEP_W)) begin : g_bad_step
    $error("dqn_sequencer: MAX_STEP must be >= 1 and fit in STEP_W bits");
  end
  if (MAX_EPISODE < 1 || MAX_EPISODE >= (1 << EP_W)) begin : g_bad_episode
    $error("dqn_sequencer: MAX_EPISODE must be >= 1 and fit in EP_W bits");
  end

  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(PHASES);
  localparam logic [PH_W-1:0]   PH_ONE   = PH_W'(1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEP);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [EP_W-1:0]   EP_MAX   = EP_W'(MAX_EPISODE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_d;
  logic [STEP_W-1:0]   step_d;
  logic [EP_W-1:0]     episode_d;
  logic                step_end_d, episode_end_d, term_goal_d;
  logic                advance, wrap, goal_hit, ep_over, budget_out;
  logic [EP_W-1:0]     ep_inc;

  assign advance    = (state_q == S_RUN) && !hold;
  assign wrap       = advance && (phase == PH_LAST);
  assign goal_hit   = (st1 == goal_state);
  assign ep_over    = wrap && (goal_hit || (step == STEP_MAX));
  assign ep_inc     = episode + EP_W'(1);
  assign budget_out = ep_over && (ep_inc == EP_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase       <= '0;
      step        <= '0;
      episode     <= '0;
      step_end    <= 1'b0;
      episode_end <= 1'b0;
      term_goal   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase       <= phase_d;
      step        <= step_d;
      episode     <= episode_d;
      step_end    <= step_end_d;
      episode_end <= episode_end_d;
      term_goal   <= term_goal_d;
      busy        <= (state_d == S_RUN);
      done        <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (budget_out) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    phase_d       = phase;
    step_d        = step;
    episode_d     = episode;
    step_end_d    = 1'b0;
    episode_end_d = 1'b0;
    term_goal_d   = 1'b0;
    if (state_q != S_RUN) begin
      if (start) begin
        phase_d   = PH_ONE;
        step_d    = STEP_ONE;
        episode_d = '0;
      end
    end else if (advance) begin
      if (!wrap) begin
        phase_d = phase + PH_ONE;
      end else begin
        phase_d    = PH_ONE;
        step_end_d = 1'b1;
        if (ep_over) begin
          episode_d     = ep_inc;
          step_d        = STEP_ONE;
          episode_end_d = 1'b1;
          term_goal_d   = goal_hit;
          // Budget exhausted: park counters at zero while the pulses still fire.
          if (budget_out) begin
            phase_d = '0;
            step_d  = '0;
          end
        end else begin
          step_d = step + STEP_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dqn_sequencer.sv
// Scoreboard bench for dqn_sequencer: default-parameter instance checked against a behavioural model,
// plus a small-budget instance for the DONE path.
module tb_dqn_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, hold;
  logic [3:0] st1, goal_state;
  logic [3:0] phase, step;
  logic [11:0] episode;
  logic       step_end, episode_end, term_goal, busy, done;

  logic       rst2, start2;
  logic [1:0] phase2, step2, episode2;
  logic       step_end2, episode_end2, term_goal2, busy2, done2;

  dqn_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .st1(st1), .goal_state(goal_state),
    .phase(phase), .step(step), .episode(episode), .step_end(step_end),
    .episode_end(episode_end), .term_goal(term_goal), .busy(busy), .done(done)
  );

  dqn_sequencer #(.PHASES(3), .MAX_STEP(2), .MAX_EPISODE(2), .PH_W(2), .STEP_W(2), .EP_W(2))
  dut_small (
    .clk(clk), .rst(rst2), .start(start2), .hold(1'b0), .st1(4'd1), .goal_state(4'd9),
    .phase(phase2), .step(step2), .episode(episode2), .step_end(step_end2),
    .episode_end(episode_end2), .term_goal(term_goal2), .busy(busy2), .done(done2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of the default instance; state 0 idle, 1 run, 2 done.
  int m_st = 0, m_ph = 0, m_step = 0, m_ep = 0;
  bit m_se = 0, m_ee = 0, m_tg = 0;
  logic [24:0] exp_q[$];

  function automatic logic [24:0] pack_model();
    return {m_ph[3:0], m_step[3:0], m_ep[11:0], m_se, m_ee, m_tg, (m_st == 1), (m_st == 2)};
  endfunction

  task automatic model_step();
    bit g;
    m_se = 0; m_ee = 0; m_tg = 0;
    if (rst) begin
      m_st = 0; m_ph = 0; m_step = 0; m_ep = 0;
    end else if (m_st != 1) begin
      if (start) begin m_st = 1; m_ph = 1; m_step = 1; m_ep = 0; end
    end else if (!hold) begin
      if (m_ph < 9) m_ph++;
      else begin
        m_se = 1; m_ph = 1;
        g = (st1 == goal_state);
        if (g || m_step == 15) begin
          m_ee = 1; m_tg = g; m_ep++; m_step = 1;
          if (m_ep == 4095) begin m_st = 2; m_ph = 0; m_step = 0; end
        end else m_step++;
      end
    end
    exp_q.push_back(pack_model());
  endtask

  task automatic tick();
    logic [24:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = exp_q.pop_front();
      chk("sb_outs", {7'd0, phase, step, episode, step_end, episode_end, term_goal, busy, done}, {7'd0, e});
    end
  endtask

  task automatic restart();
    rst = 1; tick(); rst = 0;
    start = 1; tick(); start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_se, n;
    rst = 1; start = 0; hold = 0; st1 = 4'd1; goal_state = 4'd9;
    rst2 = 1; start2 = 0;
    tick(); tick();
    rst2 = 0;
    chk("rst_phase", phase, 0);
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {step_end, episode_end, term_goal, done}, 0);

    // Timeout episode
    rst = 0; start = 1; tick(); start = 0;
    chk("start_phase", phase, 1);
    chk("start_busy", busy, 1);
    first_se = -1;
    for (int e = 1; e <= 135; e++) begin
      tick();
      if (step_end && first_se < 0) first_se = e;
    end
    chk("to_first_se", first_se, 9);
    chk("to_ee", {episode_end, term_goal}, 2'b10);
    chk("to_counts", {phase, step, episode}, {4'd1, 4'd1, 12'd1});

    // Goal in step 3
    restart();
    for (int e = 1; e <= 26; e++) tick();
    st1 = 4'd9; tick(); st1 = 4'd1;
    chk("goal_ee", {episode_end, term_goal, step_end}, 3'b111);
    chk("goal_counts", {phase, step, episode}, {4'd1, 4'd1, 12'd1});
    tick();
    chk("goal_pulse_clr", {episode_end, term_goal}, 0);

    // Hold at phase 4
    restart();
    for (int e = 1; e <= 3; e++) tick();
    hold = 1;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk("hold_phase", phase, 4);
    end
    hold = 0;
    n = 0;
    while (n < 20) begin
      tick(); n++;
      if (step_end) break;
    end
    chk("hold_se_edge", 8 + n, 14);

    // Start ignored in RUN
    start = 1; tick(); start = 0;
    chk("start_in_run", {phase, step}, {4'd2, 4'd2});

    // Reset mid-run at step 5 phase 6
    restart();
    for (int e = 1; e <= 41; e++) tick();
    chk("pre_rst", {phase, step}, {4'd6, 4'd5});
    st1 = 4'd9;
    rst = 1; tick(); rst = 0;
    chk("midrst_all", {phase, step, episode, step_end, episode_end, term_goal, busy, done}, 0);
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("midrst_idle", busy, 0);
    end
    st1 = 4'd1;

    // Budget on the small instance
    start2 = 1; tick(); start2 = 0;
    for (int e = 1; e <= 12; e++) tick();
    chk("bud_done", {done2, busy2, episode_end2, step_end2}, 4'b1011);
    chk("bud_counts", {phase2, step2, episode2}, {2'd0, 2'd0, 2'd2});
    tick(); tick();
    chk("bud_hold", {done2, episode_end2, episode2}, {1'b1, 1'b0, 2'd2});
    start2 = 1; tick(); start2 = 0;
    chk("bud_restart", {phase2, step2, episode2, busy2, done2}, {2'd1, 2'd1, 2'd0, 1'b1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
